// File: rtl/ips2l_pcie_dma_rx_stream_buf.sv
// RX completion-stream buffer: FWFT FIFO with a one-word output register feeding an AXI4-Stream master.
// Optional macro IPS2L_PCIE_DMA_RX_BUF_SWAP_EN byte-reverses each 32-bit DW at the output register.
module ips2l_pcie_dma_rx_stream_buf #(
    parameter int DEPTH_LOG2   = 9,
    parameter int PKT_WORDS    = 16,
    parameter int AFULL_MARGIN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_dma_wr_en,
    input  logic [127:0]          i_dma_wr_data,
    input  logic                  i_dma_wr_last,
    input  logic                  i_restart,
    output logic                  o_axis_tvalid,
    input  logic                  i_axis_tready,
    output logic [127:0]          o_axis_tdata,
    output logic                  o_axis_tlast,
    output logic [DEPTH_LOG2:0]   o_fifo_cnt,
    output logic                  o_almost_full,
    output logic                  o_overflow,
    output logic [31:0]           o_pkt_cnt
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AF_THR    = (DEPTH_LOG2+1)'(AFULL_MARGIN);
    localparam logic [7:0]          BEAT_LAST = 8'(PKT_WORDS - 1);

    typedef enum logic {ST_EMPTY, ST_VALID} state_t;

    state_t state_reg, state_next;

    logic [128:0]          ram [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_LOG2:0]   rd_ptr_reg, rd_ptr_next;
    logic [DEPTH_LOG2:0]   cnt_reg, cnt_next;
    logic [127:0]          data_reg, data_next;
    logic                  tag_reg, tag_next;
    logic                  tlast_reg, tlast_next;
    logic [7:0]            beat_reg, beat_next;
    logic                  af_reg, af_next;
    logic                  ovf_reg, ovf_next;
    logic [31:0]           pkt_reg, pkt_next;

    logic                  full, accept, pop, ram_empty;
    logic                  load_ram, load_wr, ram_we;
    logic [128:0]          ram_head;
    logic [127:0]          src_word, out_word;
    logic                  src_tag;

    assign full      = (cnt_reg == DEPTH_CNT);
    assign accept    = i_dma_wr_en & ~full & ~i_restart;
    assign pop       = (state_reg == ST_VALID) & i_axis_tready;
    assign ram_empty = (wr_ptr_reg == rd_ptr_reg);
    // RAM only holds words behind the output register, so EMPTY implies an empty RAM.
    assign load_ram  = pop & ~ram_empty & ~i_restart;
    assign load_wr   = accept & ((state_reg == ST_EMPTY) | (pop & ram_empty));
    assign ram_we    = accept & ~load_wr;

    assign ram_head  = ram[rd_ptr_reg[DEPTH_LOG2-1:0]];
    assign src_word  = load_ram ? ram_head[127:0] : i_dma_wr_data;
    assign src_tag   = load_ram ? ram_head[128]   : i_dma_wr_last;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_byte
`ifdef IPS2L_PCIE_DMA_RX_BUF_SWAP_EN
            assign out_word[gi*8 +: 8] = src_word[((gi/4)*4 + (3 - gi%4))*8 +: 8];
`else
            assign out_word[gi*8 +: 8] = src_word[gi*8 +: 8];
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[wr_ptr_reg[DEPTH_LOG2-1:0]] <= {i_dma_wr_last, i_dma_wr_data};
        end
    end

    always_comb begin
        state_next  = state_reg;
        data_next   = data_reg;
        tag_next    = tag_reg;
        beat_next   = beat_reg;
        pkt_next    = pkt_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        cnt_next    = cnt_reg;
        ovf_next    = ovf_reg;

        case (state_reg)
            ST_EMPTY: if (load_wr) state_next = ST_VALID;
            ST_VALID: if (pop && !load_ram && !load_wr) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase

        if (load_ram || load_wr) begin
            data_next = out_word;
            tag_next  = src_tag;
        end

        if (pop) begin
            if (tlast_reg) begin
                beat_next = 8'd0;
                pkt_next  = pkt_reg + 32'd1;
            end else begin
                beat_next = beat_reg + 8'd1;
            end
        end

        if (ram_we)   wr_ptr_next = wr_ptr_reg + 1'b1;
        if (load_ram) rd_ptr_next = rd_ptr_reg + 1'b1;

        case ({accept, pop})
            2'b10:   cnt_next = cnt_reg + 1'b1;
            2'b01:   cnt_next = cnt_reg - 1'b1;
            default: cnt_next = cnt_reg;
        endcase

        // A drop is judged against the pre-pop count, so a pop cannot rescue it.
        if (i_dma_wr_en && full) ovf_next = 1'b1;

        if (i_restart) begin
            state_next  = ST_EMPTY;
            data_next   = '0;
            tag_next    = 1'b0;
            beat_next   = 8'd0;
            pkt_next    = 32'd0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            cnt_next    = '0;
            ovf_next    = 1'b0;
        end

        tlast_next = (state_next == ST_VALID) & (tag_next | (beat_next == BEAT_LAST));
        af_next    = ((DEPTH_CNT - cnt_next) <= AF_THR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_EMPTY;
            data_reg   <= '0;
            tag_reg    <= 1'b0;
            tlast_reg  <= 1'b0;
            beat_reg   <= 8'd0;
            pkt_reg    <= 32'd0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
            af_reg     <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            data_reg   <= data_next;
            tag_reg    <= tag_next;
            tlast_reg  <= tlast_next;
            beat_reg   <= beat_next;
            pkt_reg    <= pkt_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            cnt_reg    <= cnt_next;
            af_reg     <= af_next;
            ovf_reg    <= ovf_next;
        end
    end

    assign o_axis_tvalid = (state_reg == ST_VALID);
    assign o_axis_tdata  = data_reg;
    assign o_axis_tlast  = tlast_reg;
    assign o_fifo_cnt    = cnt_reg;
    assign o_almost_full = af_reg;
    assign o_overflow    = ovf_reg;
    assign o_pkt_cnt     = pkt_reg;

endmodule

// File: tb/tb_ips2l_pcie_dma_rx_stream_buf.sv
// Directed bench for ips2l_pcie_dma_rx_stream_buf (default build, DEPTH_LOG2=9, PKT_WORDS=16).
module tb_ips2l_pcie_dma_rx_stream_buf;
    logic         clk = 1'b0;
    logic         rst;
    logic         i_dma_wr_en;
    logic [127:0] i_dma_wr_data;
    logic         i_dma_wr_last;
    logic         i_restart;
    logic         o_axis_tvalid;
    logic         i_axis_tready;
    logic [127:0] o_axis_tdata;
    logic         o_axis_tlast;
    logic [9:0]   o_fifo_cnt;
    logic         o_almost_full;
    logic         o_overflow;
    logic [31:0]  o_pkt_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ips2l_pcie_dma_rx_stream_buf #(.DEPTH_LOG2(9), .PKT_WORDS(16), .AFULL_MARGIN(32)) dut (
        .clk(clk), .rst(rst),
        .i_dma_wr_en(i_dma_wr_en), .i_dma_wr_data(i_dma_wr_data), .i_dma_wr_last(i_dma_wr_last),
        .i_restart(i_restart),
        .o_axis_tvalid(o_axis_tvalid), .i_axis_tready(i_axis_tready),
        .o_axis_tdata(o_axis_tdata), .o_axis_tlast(o_axis_tlast),
        .o_fifo_cnt(o_fifo_cnt), .o_almost_full(o_almost_full),
        .o_overflow(o_overflow), .o_pkt_cnt(o_pkt_cnt)
    );

    function automatic logic [127:0] mk(input int i);
        mk = {32'(i) ^ 32'hDEAD0000, 32'(i + 1), ~32'(i), 32'(i)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; i_restart = 1'b0; i_dma_wr_en = 1'b0; i_dma_wr_data = '0;
        i_dma_wr_last = 1'b0; i_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (o_axis_tvalid !== 1'b0 || o_axis_tlast !== 1'b0 || o_axis_tdata !== 128'd0) begin
            tests_failed++;
            $display("FAIL reset_axis: tvalid=%b tlast=%b tdata=%h, want 0/0/0", o_axis_tvalid, o_axis_tlast, o_axis_tdata);
        end
        tests_run++;
        if (o_fifo_cnt !== 10'd0 || o_almost_full !== 1'b0 || o_overflow !== 1'b0 || o_pkt_cnt !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_status: cnt=%0d af=%b ovf=%b pkt=%0d, want 0/0/0/0", o_fifo_cnt, o_almost_full, o_overflow, o_pkt_cnt);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_back_to_back();
        int nbeats = 0;
        int first_c = -1;
        int last_c = -1;
        i_axis_tready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            i_dma_wr_en   = (c < 32);
            i_dma_wr_data = mk(c);
            i_dma_wr_last = 1'b0;
            if (o_axis_tvalid) begin
                $display("[TB] b2b beat %0d data=%h last=%b", nbeats, o_axis_tdata, o_axis_tlast);
                tests_run++;
                if (o_axis_tdata !== mk(nbeats) || o_axis_tlast !== ((nbeats % 16) == 15)) begin
                    tests_failed++;
                    $display("FAIL b2b_beat%0d: data=%h last=%b, want %h/%b", nbeats, o_axis_tdata, o_axis_tlast,
                             mk(nbeats), ((nbeats % 16) == 15));
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                nbeats++;
            end
        end
        i_dma_wr_en = 1'b0;
        tests_run++;
        if (first_c !== 1) begin
            tests_failed++;
            $display("FAIL b2b_latency: first beat at cycle %0d, want 1", first_c);
        end
        tests_run++;
        if (nbeats !== 32 || (last_c - first_c + 1) !== 32) begin
            tests_failed++;
            $display("FAIL b2b_stream: beats=%0d span=%0d, want 32/32", nbeats, last_c - first_c + 1);
        end
        tests_run++;
        if (o_pkt_cnt !== 32'd2) begin
            tests_failed++;
            $display("FAIL b2b_pkt_cnt: got %0d, want 2", o_pkt_cnt);
        end
    endtask

    task automatic test_short();
        int nbeats = 0;
        i_axis_tready = 1'b1;
        for (int c = 0; c < 28; c++) begin
            @(negedge clk);
            i_dma_wr_en   = (c < 21);
            i_dma_wr_data = mk(100 + c);
            i_dma_wr_last = (c == 4);
            if (o_axis_tvalid) begin
                $display("[TB] short beat %0d data=%h last=%b", nbeats, o_axis_tdata, o_axis_tlast);
                tests_run++;
                if (o_axis_tdata !== mk(100 + nbeats) || o_axis_tlast !== (nbeats == 4 || nbeats == 20)) begin
                    tests_failed++;
                    $display("FAIL short_beat%0d: data=%h last=%b, want %h/%b", nbeats, o_axis_tdata, o_axis_tlast,
                             mk(100 + nbeats), (nbeats == 4 || nbeats == 20));
                end
                nbeats++;
            end
        end
        i_dma_wr_en = 1'b0; i_dma_wr_last = 1'b0;
        tests_run++;
        if (nbeats !== 21 || o_pkt_cnt !== 32'd4) begin
            tests_failed++;
            $display("FAIL short_totals: beats=%0d pkt=%0d, want 21/4", nbeats, o_pkt_cnt);
        end
    endtask

    task automatic test_stall();
        int rx;
        i_axis_tready = 1'b0;
        for (int i = 0; i <= 512; i++) begin
            @(negedge clk);
            if (i == 479) begin
                tests_run++;
                if (o_almost_full !== 1'b0 || o_fifo_cnt !== 10'd479) begin
                    tests_failed++;
                    $display("FAIL stall_af479: af=%b cnt=%0d, want 0/479", o_almost_full, o_fifo_cnt);
                end
            end
            if (i == 480) begin
                tests_run++;
                if (o_almost_full !== 1'b1 || o_fifo_cnt !== 10'd480) begin
                    tests_failed++;
                    $display("FAIL stall_af480: af=%b cnt=%0d, want 1/480", o_almost_full, o_fifo_cnt);
                end
            end
            if (i == 512) begin
                tests_run++;
                if (o_fifo_cnt !== 10'd512 || o_overflow !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL stall_full: cnt=%0d ovf=%b, want 512/0", o_fifo_cnt, o_overflow);
                end
            end
            i_dma_wr_en   = 1'b1;
            i_dma_wr_data = (i == 512) ? mk(9999) : mk(1000 + i);
        end
        @(negedge clk);
        tests_run++;
        if (o_fifo_cnt !== 10'd512 || o_overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_drop: cnt=%0d ovf=%b, want 512/1", o_fifo_cnt, o_overflow);
        end
        // write and pop together while full
        i_dma_wr_en = 1'b1; i_dma_wr_data = mk(8888); i_axis_tready = 1'b1;
        tests_run++;
        if (o_axis_tvalid !== 1'b1 || o_axis_tdata !== mk(1000)) begin
            tests_failed++;
            $display("FAIL full_pop_head: tvalid=%b data=%h, want 1/%h", o_axis_tvalid, o_axis_tdata, mk(1000));
        end
        rx = 1;
        @(negedge clk);
        i_dma_wr_en = 1'b0;
        tests_run++;
        if (o_fifo_cnt !== 10'd511 || o_overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_pop_cnt: cnt=%0d ovf=%b, want 511/1", o_fifo_cnt, o_overflow);
        end
        for (int c = 0; c < 700; c++) begin
            if (c > 0) @(negedge clk);
            if (o_axis_tvalid) begin
                tests_run++;
                if (o_axis_tdata !== mk(1000 + rx)) begin
                    tests_failed++;
                    $display("FAIL drain_word%0d: data=%h, want %h", rx, o_axis_tdata, mk(1000 + rx));
                end
                rx++;
            end
        end
        tests_run++;
        if (rx !== 512 || o_fifo_cnt !== 10'd0 || o_axis_tvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_total: words=%0d cnt=%0d tvalid=%b, want 512/0/0", rx, o_fifo_cnt, o_axis_tvalid);
        end
        $display("[TB] stall drained %0d words", rx);
    endtask

    task automatic test_restart();
        int nbeats = 0;
        i_axis_tready = 1'b0;
        for (int i = 0; i < 103; i++) begin
            @(negedge clk);
            i_dma_wr_en = 1'b1; i_dma_wr_data = mk(3000 + i);
        end
        @(negedge clk);
        i_dma_wr_en = 1'b0; i_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            tests_run++;
            if (o_axis_tdata !== mk(3000 + i)) begin
                tests_failed++;
                $display("FAIL restart_prepop%0d: data=%h, want %h", i, o_axis_tdata, mk(3000 + i));
            end
        end
        @(negedge clk);
        i_axis_tready = 1'b0;
        tests_run++;
        if (o_fifo_cnt !== 10'd100) begin
            tests_failed++;
            $display("FAIL restart_precnt: cnt=%0d, want 100", o_fifo_cnt);
        end
        i_restart = 1'b1; i_dma_wr_en = 1'b1; i_dma_wr_data = mk(7777);
        @(negedge clk);
        i_restart = 1'b0; i_dma_wr_en = 1'b0;
        tests_run++;
        if (o_fifo_cnt !== 10'd0 || o_axis_tvalid !== 1'b0 || o_overflow !== 1'b0 || o_pkt_cnt !== 32'd0) begin
            tests_failed++;
            $display("FAIL restart_clear: cnt=%0d tvalid=%b ovf=%b pkt=%0d, want 0/0/0/0",
                     o_fifo_cnt, o_axis_tvalid, o_overflow, o_pkt_cnt);
        end
        i_axis_tready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            i_dma_wr_en = (c < 16); i_dma_wr_data = mk(4000 + c);
            if (o_axis_tvalid) begin
                tests_run++;
                if (o_axis_tdata !== mk(4000 + nbeats) || o_axis_tlast !== (nbeats == 15)) begin
                    tests_failed++;
                    $display("FAIL restart_beat%0d: data=%h last=%b, want %h/%b", nbeats, o_axis_tdata,
                             o_axis_tlast, mk(4000 + nbeats), (nbeats == 15));
                end
                nbeats++;
            end
        end
        i_dma_wr_en = 1'b0;
        tests_run++;
        if (nbeats !== 16 || o_pkt_cnt !== 32'd1) begin
            tests_failed++;
            $display("FAIL restart_pkt: beats=%0d pkt=%0d, want 16/1", nbeats, o_pkt_cnt);
        end
        $display("[TB] restart done");
    endtask

    task automatic test_hold();
        int tx = 0;
        int rx = 0;
        int beat = 0;
        logic exp_last;
        logic prev_stall = 1'b0;
        logic [127:0] prev_data = '0;
        logic prev_last = 1'b0;
        for (int c = 0; c < 20000 && rx < 1000; c++) begin
            @(negedge clk);
            if (prev_stall) begin
                tests_run++;
                if (o_axis_tvalid !== 1'b1 || o_axis_tdata !== prev_data || o_axis_tlast !== prev_last) begin
                    tests_failed++;
                    $display("FAIL hold_stable%0d: tvalid=%b data=%h last=%b, want 1/%h/%b", rx, o_axis_tvalid,
                             o_axis_tdata, o_axis_tlast, prev_data, prev_last);
                end
            end
            i_axis_tready = ($urandom_range(0, 99) < 55);
            i_dma_wr_en   = (tx < 1000) && ($urandom_range(0, 1) == 1);
            i_dma_wr_data = mk(5000 + tx);
            i_dma_wr_last = ((tx % 7) == 6);
            if (i_dma_wr_en) tx++;
            if (o_axis_tvalid && i_axis_tready) begin
                exp_last = ((rx % 7) == 6) || (beat == 15);
                tests_run++;
                if (o_axis_tdata !== mk(5000 + rx) || o_axis_tlast !== exp_last) begin
                    tests_failed++;
                    $display("FAIL hold_word%0d: data=%h last=%b, want %h/%b", rx, o_axis_tdata, o_axis_tlast,
                             mk(5000 + rx), exp_last);
                end
                beat = exp_last ? 0 : beat + 1;
                rx++;
            end
            prev_stall = o_axis_tvalid && !i_axis_tready;
            prev_data  = o_axis_tdata;
            prev_last  = o_axis_tlast;
        end
        @(negedge clk);
        i_dma_wr_en = 1'b0; i_dma_wr_last = 1'b0;
        tests_run++;
        if (rx !== 1000 || tx !== 1000 || o_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_totals: rx=%0d tx=%0d ovf=%b, want 1000/1000/0", rx, tx, o_overflow);
        end
        $display("[TB] hold stream received %0d words", rx);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_short();
        test_stall();
        test_restart();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
